jtframe_dwnld_sdram: RTL and testbench

Consumer end of the ROM download byte stream (ioctl_addr/ioctl_data/ioctl_wr/downloading) produced by the SPI io-controller interface.
- Decodes each byte address into an SDRAM bank, word address and byte mask.
- Buffers bytes in a small FIFO and drives the prog_* write port of the SDRAM controller with a request/ready handshake.
- Generates dwnld_busy so game and board logic stay in reset until every byte has reached SDRAM.
- Sits between the MiST base block and jtframe_board, in the clk_rom domain.

---
 rtl/jtframe_dwnld_sdram.sv | 212 +++++++++++++++++++++
 tb/tb_jtframe_dwnld_sdram.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_sdram.sv
// ROM download consumer: decodes io-controller bytes into SDRAM bank/word/mask writes buffered by a small FIFO.
// Optional PROM bypass port enabled with `define JTFRAME_DWNLD_PROM_EN.
module jtframe_dwnld_sdram #(
  parameter logic [24:0] BA1_START   = 25'h040000,
  parameter logic [24:0] BA2_START   = 25'h080000,
  parameter logic [24:0] BA3_START   = 25'h0C0000,
  parameter int          FIFO_AW     = 2,
  parameter int          HOLD_CYCLES = 16
`ifdef JTFRAME_DWNLD_PROM_EN
  ,parameter logic [24:0] PROM_START = 25'h100000
`endif
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
`ifdef JTFRAME_DWNLD_PROM_EN
  ,output logic       prom_we,
  output logic [9:0]  prom_addr
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HW    = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  logic [1:0]         bank_s;
  logic [22:0]        offset_s;
  logic [33:0]        entry_s;
  logic               is_prom_s;
  logic               dec_valid_r;
  logic [33:0]        dec_entry_r;
  logic [33:0]        mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   cnt_r;
  state_t             state_r, state_nx_s;
  logic               pop_s, push_s, full_s, load_s;
  logic [33:0]        head_s;
  logic [HW-1:0]      hold_r;
  logic               idle_s;

  // Address decode: bank select and 23-bit in-bank offset (upper bits wrap away)
  always_comb begin
    bank_s   = 2'd0;
    offset_s = ioctl_addr[22:0];
    if (ioctl_addr < BA1_START) begin
      bank_s   = 2'd0;
      offset_s = ioctl_addr[22:0];
    end else if (ioctl_addr < BA2_START) begin
      bank_s   = 2'd1;
      offset_s = 23'(ioctl_addr - BA1_START);
    end else if (ioctl_addr < BA3_START) begin
      bank_s   = 2'd2;
      offset_s = 23'(ioctl_addr - BA2_START);
    end else begin
      bank_s   = 2'd3;
      offset_s = 23'(ioctl_addr - BA3_START);
    end
    entry_s = {bank_s, offset_s[22:1], (offset_s[0] ? 2'b01 : 2'b10), ioctl_data};
`ifdef JTFRAME_DWNLD_PROM_EN
    is_prom_s = ioctl_addr >= PROM_START;
`else
    is_prom_s = 1'b0;
`endif
  end

  // Decode pipeline register
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      dec_valid_r <= 1'b0;
      dec_entry_r <= 34'd0;
    end else begin
      dec_valid_r <= ioctl_wr & ~is_prom_s;
      dec_entry_r <= entry_s;
    end
  end

  assign full_s = cnt_r == (FIFO_AW+1)'(DEPTH);
  assign pop_s  = (state_r == S_WAIT) & prog_rdy;
  // a full FIFO still accepts a byte when its head is retired in the same cycle
  assign push_s = dec_valid_r & (~full_s | pop_s);

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= dec_entry_r;
        wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (FIFO_AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (FIFO_AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (dec_valid_r & ~push_s) overflow <= 1'b1;
    end
  end

  // Write port state register
  always_ff @(posedge clk_rom) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nx_s;
  end

  // Write port next state
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cnt_r != '0 || push_s) state_nx_s = S_WAIT;
        else                       state_nx_s = S_IDLE;
      end
      S_WAIT: begin
        if (pop_s) state_nx_s = (cnt_r > (FIFO_AW+1)'(1) || push_s) ? S_WAIT : S_IDLE;
        else       state_nx_s = S_WAIT;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Write port load select; an empty FIFO forwards the byte being pushed
  always_comb begin
    load_s = 1'b0;
    head_s = dec_entry_r;
    case (state_r)
      S_IDLE: begin
        if (cnt_r != '0) begin
          load_s = 1'b1;
          head_s = mem_r[rd_ptr_r];
        end else if (push_s) begin
          load_s = 1'b1;
          head_s = dec_entry_r;
        end else begin
          load_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (pop_s && cnt_r > (FIFO_AW+1)'(1)) begin
          load_s = 1'b1;
          head_s = mem_r[rd_ptr_r + FIFO_AW'(1)];
        end else if (pop_s && push_s) begin
          load_s = 1'b1;
          head_s = dec_entry_r;
        end else begin
          load_s = 1'b0;
        end
      end
      default: load_s = 1'b0;
    endcase
  end

  // Registered SDRAM write port (and PROM bypass when enabled)
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      prog_bank <= 2'd0;
      prog_addr <= 22'd0;
      prog_mask <= 2'd0;
      prog_data <= 8'd0;
      prog_we   <= 1'b0;
`ifdef JTFRAME_DWNLD_PROM_EN
      prom_we   <= 1'b0;
      prom_addr <= 10'd0;
`endif
    end else begin
      prog_we <= state_nx_s == S_WAIT;
      if (load_s) {prog_bank, prog_addr, prog_mask, prog_data} <= head_s;
`ifdef JTFRAME_DWNLD_PROM_EN
      prom_we   <= ioctl_wr & is_prom_s;
      prom_addr <= 10'(ioctl_addr - PROM_START);
      if (ioctl_wr && is_prom_s && !load_s) prog_data <= ioctl_data;
`endif
    end
  end

  assign idle_s = ~downloading & (cnt_r == '0) & ~prog_we & ~dec_valid_r;

  // Busy flag with post-download hold counter
  always_ff @(posedge clk_rom) begin
    if (rst) begin
      dwnld_busy <= 1'b0;
      hold_r     <= '0;
    end else if (downloading) begin
      dwnld_busy <= 1'b1;
      hold_r     <= '0;
    end else if (!dwnld_busy || ioctl_wr || !idle_s) begin
      hold_r <= '0;
    end else if (hold_r == HW'(HOLD_CYCLES - 1)) begin
      dwnld_busy <= 1'b0;
      hold_r     <= '0;
    end else begin
      hold_r <= hold_r + HW'(1);
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_sdram.sv
// Bench for jtframe_dwnld_sdram: directed cases plus randomized traffic against a queue-based reference model.
module tb_jtframe_dwnld_sdram;

  logic        clk_rom = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        dwnld_busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  // reference model state: queue of outstanding writes, head is the one on the port
  logic [33:0] q [$];
  logic        pv = 1'b0;
  logic [33:0] pe = 34'd0;
  logic        ovf_m = 1'b0;

  jtframe_dwnld_sdram dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow)
  );

  always #5 clk_rom = ~clk_rom;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] model_decode(input logic [24:0] a, input logic [7:0] d);
    int unsigned off;
    logic [1:0]  b;
    if (a < 25'h040000)      begin b = 2'd0; off = a; end
    else if (a < 25'h080000) begin b = 2'd1; off = a - 25'h040000; end
    else if (a < 25'h0C0000) begin b = 2'd2; off = a - 25'h080000; end
    else                     begin b = 2'd3; off = a - 25'h0C0000; end
    off = off % (1 << 23);
    return {b, 22'(off / 2), ((off % 2) == 1) ? 2'b01 : 2'b10, d};
  endfunction

  // one clock: advance the model with the inputs seen at the edge, then compare
  task automatic cycle();
    @(posedge clk_rom);
    if (rst) begin
      q.delete();
      pv    = 1'b0;
      ovf_m = 1'b0;
    end else begin
      if (prog_rdy && q.size() > 0) void'(q.pop_front());
      if (pv) begin
        if (q.size() < 4) q.push_back(pe);
        else              ovf_m = 1'b1;
      end
      pv = ioctl_wr;
      pe = model_decode(ioctl_addr, ioctl_data);
    end
    @(negedge clk_rom);
    chk("prog_we", 64'(prog_we), 64'(q.size() > 0));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    if (q.size() > 0) chk("entry", 64'({prog_bank, prog_addr, prog_mask, prog_data}), 64'(q[0]));
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    cycle();
    ioctl_wr   = 1'b0;
  endtask

  task automatic rdy_pulse();
    prog_rdy = 1'b1;
    cycle();
    prog_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_busy", 64'(dwnld_busy), 64'd0);
    chk("rst_we", 64'(prog_we), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_port", 64'({prog_bank, prog_addr, prog_mask, prog_data}), 64'd0);

    // latency and first decode
    wr_byte(25'h000005, 8'hA5);
    chk("lat_n1", 64'(prog_we), 64'd0);
    cycle();
    chk("lat_n2", 64'(prog_we), 64'd1);
    chk("b0_port", 64'({prog_bank, prog_addr, prog_mask, prog_data}), {30'd0, 2'd0, 22'h2, 2'b01, 8'hA5});
    rdy_pulse();
    chk("rdy_drop", 64'(prog_we), 64'd0);

    wr_byte(25'h040000, 8'h11);
    cycle();
    chk("b1_port", 64'({prog_bank, prog_addr, prog_mask}), {38'd0, 2'd1, 22'h0, 2'b10});
    rdy_pulse();
    wr_byte(25'h0C0003, 8'h22);
    cycle();
    chk("b3_port", 64'({prog_bank, prog_addr, prog_mask}), {38'd0, 2'd3, 22'h1, 2'b01});
    rdy_pulse();
    cycle();

    // overflow: six back-to-back bytes, no acceptance
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 25'(i * 2);
      ioctl_data = 8'(8'h10 + i);
      ioctl_wr   = 1'b1;
      cycle();
    end
    ioctl_wr = 1'b0;
    repeat (3) cycle();
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(prog_data), 64'(8'h10 + i));
      rdy_pulse();
    end
    chk("ovf_drain", 64'(prog_we), 64'd0);
    repeat (3) cycle();
    do_reset();

    // busy hold after the last write
    downloading = 1'b1;
    cycle();
    chk("busy_set", 64'(dwnld_busy), 64'd1);
    wr_byte(25'h000100, 8'h31);
    wr_byte(25'h000101, 8'h32);
    downloading = 1'b0;
    repeat (4) cycle();
    chk("busy_pend", 64'(dwnld_busy), 64'd1);
    rdy_pulse();
    cycle();
    chk("busy_mid", 64'(dwnld_busy), 64'd1);
    rdy_pulse();
    for (int i = 1; i <= 16; i++) begin
      chk("busy_hold", 64'(dwnld_busy), 64'd1);
      cycle();
    end
    chk("busy_fall", 64'(dwnld_busy), 64'd0);

    // reset while writes are queued
    wr_byte(25'h000200, 8'h41);
    wr_byte(25'h000201, 8'h42);
    wr_byte(25'h000202, 8'h43);
    cycle();
    chk("pre_rst_we", 64'(prog_we), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_we", 64'(prog_we), 64'd0);
    chk("rst_mid_busy", 64'(dwnld_busy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      prog_rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    prog_rdy = 1'b0;
    chk("rst_no_write", 64'(prog_we), 64'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      ioctl_wr    = ($urandom % 3) == 0;
      ioctl_addr  = (($urandom % 4) == 0) ? 25'($urandom) : 25'($urandom % 25'h140000);
      ioctl_data  = 8'($urandom);
      prog_rdy    = ($urandom % 2) == 0;
      downloading = ($urandom % 8) != 0;
      cycle();
    end
    ioctl_wr    = 1'b0;
    downloading = 1'b0;
    prog_rdy    = 1'b1;
    repeat (10) cycle();
    chk("rand_drain", 64'(prog_we), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
